cva6_axi_isolator: RTL



---
 rtl/cva6_axi_isolator.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/cva6_axi_isolator.sv
// cva6_axi_isolator
//   Buffers the five AXI channels between the CVA6 core master port and the
//   m_axi_cpu port. It limits outstanding transactions per direction and can
//   drain and isolate the core's traffic on request without truncating bursts.
//
// Ports
//   aclk, areset                  clock, asynchronous active-high reset
//   s_aw_*, s_w_*, s_ar_*         request channels from the core
//   m_aw_*, m_w_*, m_ar_*         request channels to the port
//   m_b_*, m_r_*                  response channels from the port
//   s_b_*, s_r_*                  response channels to the core
//   isolate_req                   level request to drain and isolate
//   isolated_o                    high while isolated
//   wr_outstanding_o              accepted writes awaiting B
//   rd_outstanding_o              accepted reads awaiting the last R beat

// First-word-fall-through FIFO; push on full and pop on empty are excluded by
// the caller.
module cva6_axi_isolator_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + PTR_ONE;
            if (i_pop)  r_rptr <= r_rptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wptr[AW-1:0]] <= i_data;
    end

    assign o_data  = r_mem[r_rptr[AW-1:0]];
    assign o_empty = (r_wptr == r_rptr);
    // Same index with differing wrap bit means full.
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
endmodule

module cva6_axi_isolator #(
    parameter int unsigned DEPTH           = 2,
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter int unsigned AW_WIDTH        = 64,
    parameter int unsigned W_WIDTH         = 73,
    parameter int unsigned AR_WIDTH        = 64,
    parameter int unsigned B_WIDTH         = 6,
    parameter int unsigned R_WIDTH         = 70,
    localparam int unsigned CW             = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic                s_aw_valid,
    output logic                s_aw_ready,
    input  logic [AW_WIDTH-1:0] s_aw_payload,
    output logic                m_aw_valid,
    input  logic                m_aw_ready,
    output logic [AW_WIDTH-1:0] m_aw_payload,
    input  logic                s_w_valid,
    output logic                s_w_ready,
    input  logic [W_WIDTH-1:0]  s_w_payload,
    input  logic                s_w_last,
    output logic                m_w_valid,
    input  logic                m_w_ready,
    output logic [W_WIDTH-1:0]  m_w_payload,
    output logic                m_w_last,
    input  logic                s_ar_valid,
    output logic                s_ar_ready,
    input  logic [AR_WIDTH-1:0] s_ar_payload,
    output logic                m_ar_valid,
    input  logic                m_ar_ready,
    output logic [AR_WIDTH-1:0] m_ar_payload,
    input  logic                m_b_valid,
    output logic                m_b_ready,
    input  logic [B_WIDTH-1:0]  m_b_payload,
    output logic                s_b_valid,
    input  logic                s_b_ready,
    output logic [B_WIDTH-1:0]  s_b_payload,
    input  logic                m_r_valid,
    output logic                m_r_ready,
    input  logic [R_WIDTH-1:0]  m_r_payload,
    input  logic                m_r_last,
    output logic                s_r_valid,
    input  logic                s_r_ready,
    output logic [R_WIDTH-1:0]  s_r_payload,
    output logic                s_r_last,
    input  logic                isolate_req,
    output logic                isolated_o,
    output logic [CW-1:0]       wr_outstanding_o,
    output logic [CW-1:0]       rd_outstanding_o
);
    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_DRAIN    = 2'd1;
    localparam logic [1:0] ST_ISOLATED = 2'd2;

    localparam logic [CW-1:0]        CNT_MAX  = CW'(MAX_OUTSTANDING);
    localparam logic [CW-1:0]        CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic signed [CW:0]   PEND_ZERO = '0;
    localparam logic signed [CW:0]   PEND_ONE  = {{CW{1'b0}}, 1'b1};

    logic [1:0]           r_state;
    logic [CW-1:0]        r_wr_cnt;
    logic [CW-1:0]        r_rd_cnt;
    logic signed [CW:0]   r_w_pend;

    logic w_aw_full, w_aw_empty, w_w_full, w_w_empty, w_ar_full, w_ar_empty;
    logic w_b_full, w_b_empty, w_r_full, w_r_empty;
    logic [W_WIDTH:0] w_w_dout;
    logic [R_WIDTH:0] w_r_dout;
    logic w_aw_hs, w_wlast_hs, w_ar_hs, w_b_hs, w_rlast_hs, w_drained;

    // Gates are taken from registered state only, so ready never depends on
    // same-cycle valid.
    assign s_aw_ready = !areset && !w_aw_full && (r_state == ST_RUN) && (r_wr_cnt < CNT_MAX);
    assign s_ar_ready = !areset && !w_ar_full && (r_state == ST_RUN) && (r_rd_cnt < CNT_MAX);
    // W beats owed to already-accepted AWs keep flowing while draining.
    assign s_w_ready  = !areset && !w_w_full && ((r_state == ST_RUN) || (r_w_pend > PEND_ZERO));
    assign m_b_ready  = !areset && !w_b_full;
    assign m_r_ready  = !areset && !w_r_full;

    assign m_aw_valid = !w_aw_empty;
    assign m_w_valid  = !w_w_empty;
    assign m_ar_valid = !w_ar_empty;
    assign s_b_valid  = !w_b_empty;
    assign s_r_valid  = !w_r_empty;
    assign {m_w_last, m_w_payload} = w_w_dout;
    assign {s_r_last, s_r_payload} = w_r_dout;

    cva6_axi_isolator_fifo #(.WIDTH(AW_WIDTH), .DEPTH(DEPTH)) u_aw (
        .clk(aclk), .rst(areset), .i_push(s_aw_valid && s_aw_ready), .i_data(s_aw_payload),
        .i_pop(m_aw_valid && m_aw_ready), .o_data(m_aw_payload), .o_full(w_aw_full), .o_empty(w_aw_empty));
    cva6_axi_isolator_fifo #(.WIDTH(W_WIDTH + 1), .DEPTH(DEPTH)) u_w (
        .clk(aclk), .rst(areset), .i_push(s_w_valid && s_w_ready), .i_data({s_w_last, s_w_payload}),
        .i_pop(m_w_valid && m_w_ready), .o_data(w_w_dout), .o_full(w_w_full), .o_empty(w_w_empty));
    cva6_axi_isolator_fifo #(.WIDTH(AR_WIDTH), .DEPTH(DEPTH)) u_ar (
        .clk(aclk), .rst(areset), .i_push(s_ar_valid && s_ar_ready), .i_data(s_ar_payload),
        .i_pop(m_ar_valid && m_ar_ready), .o_data(m_ar_payload), .o_full(w_ar_full), .o_empty(w_ar_empty));
    cva6_axi_isolator_fifo #(.WIDTH(B_WIDTH), .DEPTH(DEPTH)) u_b (
        .clk(aclk), .rst(areset), .i_push(m_b_valid && m_b_ready), .i_data(m_b_payload),
        .i_pop(s_b_valid && s_b_ready), .o_data(s_b_payload), .o_full(w_b_full), .o_empty(w_b_empty));
    cva6_axi_isolator_fifo #(.WIDTH(R_WIDTH + 1), .DEPTH(DEPTH)) u_r (
        .clk(aclk), .rst(areset), .i_push(m_r_valid && m_r_ready), .i_data({m_r_last, m_r_payload}),
        .i_pop(s_r_valid && s_r_ready), .o_data(w_r_dout), .o_full(w_r_full), .o_empty(w_r_empty));

    assign w_aw_hs    = s_aw_valid && s_aw_ready;
    assign w_wlast_hs = s_w_valid && s_w_ready && s_w_last;
    assign w_ar_hs    = s_ar_valid && s_ar_ready;
    assign w_b_hs     = s_b_valid && s_b_ready;
    assign w_rlast_hs = s_r_valid && s_r_ready && s_r_last;

    assign w_drained = (r_wr_cnt == '0) && (r_rd_cnt == '0) && (r_w_pend == PEND_ZERO) &&
                       w_aw_empty && w_w_empty && w_ar_empty && w_b_empty && w_r_empty;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
            r_w_pend <= '0;
        end else begin
            case ({w_aw_hs, w_b_hs})
                2'b10:   r_wr_cnt <= r_wr_cnt + CNT_ONE;
                2'b01:   r_wr_cnt <= r_wr_cnt - CNT_ONE;
                default: r_wr_cnt <= r_wr_cnt;
            endcase
            case ({w_ar_hs, w_rlast_hs})
                2'b10:   r_rd_cnt <= r_rd_cnt + CNT_ONE;
                2'b01:   r_rd_cnt <= r_rd_cnt - CNT_ONE;
                default: r_rd_cnt <= r_rd_cnt;
            endcase
            case ({w_aw_hs, w_wlast_hs})
                2'b10:   r_w_pend <= r_w_pend + PEND_ONE;
                2'b01:   r_w_pend <= r_w_pend - PEND_ONE;
                default: r_w_pend <= r_w_pend;
            endcase
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state <= ST_RUN;
        end else begin
            case (r_state)
                ST_RUN:      if (isolate_req) r_state <= ST_DRAIN;
                // A dropped request aborts the drain even if it just completed.
                ST_DRAIN:    if (!isolate_req)   r_state <= ST_RUN;
                             else if (w_drained) r_state <= ST_ISOLATED;
                ST_ISOLATED: if (!isolate_req) r_state <= ST_RUN;
                default:     r_state <= ST_RUN;
            endcase
        end
    end

    assign isolated_o       = (r_state == ST_ISOLATED);
    assign wr_outstanding_o = r_wr_cnt;
    assign rd_outstanding_o = r_rd_cnt;
endmodule
